// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file. A clear engine zeroes the storage after reset or on
// request, so the storage array itself carries no reset.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic               iClk,
  input  logic               nRst,
  input  logic               iClear,
  output logic               oBusy,
  input  logic               iWrite,
  input  logic [AW-1:0]      iAddrW,
  input  logic [XLEN-1:0]    iDataW,
  input  logic [NRD*AW-1:0]  iAddrR,
  output logic [NRD*XLEN-1:0] oDataR,
  output logic [0:0]         fsm_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  logic [0:0]      state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] mem [NREGS];
  logic            w_ok;
  logic            w_zero;
  logic            wr_en;

  // Write handshake: iWrite is taken only while oBusy=0; a request seen while busy is dropped,
  // never held or queued, so the requester must retry after oBusy falls.
  assign w_ok   = {1'b0, iAddrW} < NREGS_W;
  assign w_zero = (ZERO_R0 != 0) && (iAddrW == '0);
  assign wr_en  = iWrite && !oBusy && !w_zero && w_ok;

  assign oBusy     = (state == CLEAR);
  assign fsm_state = state;

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iClear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) state <= IDLE;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  // wr_en is never set while clearing, so the two writes cannot collide.
  always_ff @(posedge iClk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    if (wr_en) mem[iAddrW] <= iDataW;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          r_zero;
    logic          r_ok;
    assign ra     = iAddrR[k*AW +: AW];
    assign r_zero = (ZERO_R0 != 0) && (ra == '0);
    assign r_ok   = {1'b0, ra} < NREGS_W;
    assign oDataR[k*XLEN +: XLEN] =
        oBusy                      ? '0 :
        r_zero                     ? '0 :
        !r_ok                      ? '0 :
        (wr_en && (iAddrW == ra))  ? iDataW :
                                     mem[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset/clear timing, write/read, bypass, zero register,
// dropped writes while busy, reset during a clear and randomised traffic against a reference array.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                iClk = 1'b0;
  logic                nRst;
  logic                iClear;
  logic                oBusy;
  logic                iWrite;
  logic [AW-1:0]       iAddrW;
  logic [XLEN-1:0]     iDataW;
  logic [NRD*AW-1:0]   iAddrR;
  logic [NRD*XLEN-1:0] oDataR;
  logic [0:0]          fsm_state;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model [NREGS];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_R0(1)) dut (
    .iClk(iClk), .nRst(nRst), .iClear(iClear), .oBusy(oBusy),
    .iWrite(iWrite), .iAddrW(iAddrW), .iDataW(iDataW),
    .iAddrR(iAddrR), .oDataR(oDataR), .fsm_state(fsm_state)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    iWrite = en;
    iAddrW = a;
    iDataW = d;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a0, input logic [XLEN-1:0] e0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] e1);
    iAddrR = {a1, a0};
    exp_q.push_back(e0);
    exp_q.push_back(e1);
  endtask

  task automatic check_rd(input string tag);
    logic [XLEN-1:0] e;
    @(negedge iClk);
    for (int k = 0; k < NRD; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_p%0d", tag, k), oDataR[k*XLEN +: XLEN], e);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_rd(input logic [AW-1:0] ra, input logic en,
                                             input logic [AW-1:0] wa, input logic [XLEN-1:0] d);
    if (ra == '0) return '0;
    if (en && wa == ra) return d;
    return model[ra];
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic en;
    logic [AW-1:0] a, r0, r1;
    logic [XLEN-1:0] d;

    for (int i = 0; i < NREGS; i++) model[i] = '0;
    nRst = 1'b0; iClear = 1'b0; iAddrR = '0;
    wr(1'b0, '0, '0);

    // reset held for three edges
    repeat (2) step();
    drive_rd(5'd0, 32'h0, 5'd31, 32'h0);
    check_rd("rst_rd");
    check("rst_busy", {31'b0, oBusy}, 32'd1);
    step();
    nRst = 1'b1;

    n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 16) begin
        drive_rd(5'd3, 32'h0, 5'd17, 32'h0);
        check_rd("rst_mid_rd");
      end
      step();
      if (!oBusy) begin n = i; break; end
    end
    check("rst_busy_cycles", n, 32);

    for (int i = 0; i < NREGS; i++) begin
      drive_rd(AW'(i), 32'h0, AW'(NREGS-1-i), 32'h0);
      check_rd("clr_rd");
      step();
    end

    // write then read, bypass visible in the write cycle
    wr(1'b1, 5'd5, 32'hDEADBEEF);
    drive_rd(5'd5, 32'hDEADBEEF, 5'd6, 32'h0);
    check_rd("wr_byp");
    step();
    model[5] = 32'hDEADBEEF;
    wr(1'b0, '0, '0);
    drive_rd(5'd5, 32'hDEADBEEF, 5'd6, 32'h0);
    check_rd("wr_rd");
    step();

    wr(1'b1, 5'd7, 32'h12345678);
    drive_rd(5'd7, 32'h12345678, 5'd7, 32'h12345678);
    check_rd("byp");
    step();
    model[7] = 32'h12345678;
    wr(1'b0, '0, '0);
    drive_rd(5'd7, 32'h12345678, 5'd7, 32'h12345678);
    check_rd("byp_hold");
    step();

    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    drive_rd(5'd0, 32'h0, 5'd5, 32'hDEADBEEF);
    check_rd("zero_byp");
    step();
    wr(1'b0, '0, '0);
    drive_rd(5'd0, 32'h0, 5'd7, 32'h12345678);
    check_rd("zero_rd");
    step();

    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, NREGS-1));
      d  = $urandom;
      r0 = (i % 4 == 0) ? a : AW'($urandom_range(0, NREGS-1));
      r1 = AW'($urandom_range(0, NREGS-1));
      wr(en, a, d);
      drive_rd(r0, ref_rd(r0, en, a, d), r1, ref_rd(r1, en, a, d));
      check_rd("rand");
      step();
      if (en && a != '0) model[a] = d;
    end
    wr(1'b0, '0, '0);

    // writes issued during a clear are dropped
    wr(1'b1, 5'd3, 32'hA5A5A5A5);
    step();
    model[3] = 32'hA5A5A5A5;
    wr(1'b0, '0, '0);
    drive_rd(5'd3, 32'hA5A5A5A5, 5'd4, model[4]);
    check_rd("pre_clr");
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 2) begin
        wr(1'b1, 5'd4, 32'h1);
        drive_rd(5'd4, 32'h0, 5'd3, 32'h0);
        check_rd("busy_rd");
      end
      if (i == 3) wr(1'b0, '0, '0);
      if (i == 21) wr(1'b1, 5'd1, 32'h55);
      if (i == 22) wr(1'b0, '0, '0);
      step();
      if (!oBusy) begin n = i; break; end
    end
    check("clr_busy_cycles", n, 32);
    drive_rd(5'd3, 32'h0, 5'd4, 32'h0);
    check_rd("busy_drop");
    drive_rd(5'd1, 32'h0, 5'd5, 32'h0);
    check_rd("busy_drop_late");
    check("clr_idle", {31'b0, oBusy}, 32'd0);
    step();

    // reset in the middle of a clear restarts it; iClear during the clear is ignored
    wr(1'b1, 5'd9, 32'hCAFEF00D);
    step();
    wr(1'b0, '0, '0);
    drive_rd(5'd9, 32'hCAFEF00D, 5'd0, 32'h0);
    check_rd("pre_mid");
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    repeat (10) step();
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    check("mid_rst_busy", {31'b0, oBusy}, 32'd1);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      iClear = (i == 5) ? 1'b1 : 1'b0;
      step();
      if (!oBusy) begin n = i; break; end
    end
    iClear = 1'b0;
    check("mid_rst_cycles", n, 32);
    drive_rd(5'd9, 32'h0, 5'd31, 32'h0);
    check_rd("mid_rst_rd");
    check("mid_idle", {31'b0, oBusy}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
